contador_embalagem: RTL and testbench
=====================================

# contador_embalagem

Packaging counter sitting directly downstream of the quality-control stage on the bottling line. Consumes that stage's `Conta` (bottle approved) and `Descarte` (bottle rejected) outputs, packs approved bottles into boxes of `CAPACIDADE` units, and counts completed boxes and discarded bottles. Stops the line while a full box waits for replacement, and raises an alarm on a run of consecutive rejects.

## Interface
- `CAPACIDADE`, 6: bottles per box; legal range 1..15.
- `LIMITE_DESCARTE`, 3: consecutive discards that raise `Alarme`; legal range 1..15.
- `CLK` in 1: single clock; all state updates on the rising edge.
- `Reset` in 1: asynchronous, active-low reset (0 = reset).
- `Conta` in 1: approved-bottle level from QC; may stay high for several cycles.
- `Descarte` in 1: rejected-bottle level from QC; may stay high for several cycles.
- `TrocaCaixa` in 1: operator/handler level; 1 = full box removed, empty box in place.
- `ItensCaixa` out 4: bottles in the current box.
- `Caixas` out 8: completed boxes; wraps 255 -> 0.
- `Descartes` out 8: total discarded bottles; saturates at 255.
- `CaixaCheia` out 1: current box full.
- `Bloqueio` out 1: line stop request to upstream; 1 while the box is full or being swapped.
- `Alarme` out 1: consecutive-discard alarm.
- `Erro` out 1: sticky fault flag.

## Operation
- Event detection: registered copies `Conta_ant` and `Descarte_ant`.
  - Approval event: `Conta=1` and `Conta_ant=0`.
  - Discard event: `Descarte=1` and `Descarte_ant=0`.
  - One event per input rising edge, regardless of how long the level is held.
- FSM states:
  - `ENCHENDO` (reset state):
    - On an approval event, `ItensCaixa` increments.
    - If the new value equals `CAPACIDADE`, go to `CHEIA`.
  - `CHEIA`:
    - `CaixaCheia=1`, `Bloqueio=1`.
    - When `TrocaCaixa=1`, go to `TROCA`.
    - An approval event here sets `Erro`; `ItensCaixa` is not changed.
  - `TROCA`:
    - `Bloqueio=1`, `CaixaCheia=0`.
    - When `TrocaCaixa=0`, clear `ItensCaixa` to 0, increment `Caixas` (mod 256), and go to `ENCHENDO`.
    - An approval event here sets `Erro`.
- Discard events are counted in every state.
  - `Descartes` increments, saturating at 255.
  - The internal 4-bit run counter increments, saturating at 15.
- Run counter and `Alarme`:
  - `Alarme=1` while the run counter is at or above `LIMITE_DESCARTE`.
  - Any approval event, including one that sets `Erro`, clears the run counter. `Alarme` drops the next cycle.
- Simultaneous approval and discard events in the same cycle:
  - Treated as a discard only.
  - `Erro` is set.
  - The run counter is not cleared.
- `Erro` is sticky and is cleared only by `Reset`.
- Reset (any time, including mid-box or mid-swap):
  - State `ENCHENDO`.
  - All counters 0, `Conta_ant=0`, `Descarte_ant=0`.
  - `ItensCaixa=0`, `Caixas=0`, `Descartes=0`, `CaixaCheia=0`, `Bloqueio=0`, `Alarme=0`, `Erro=0`.
  - If `Conta=1` is held through reset release, the first active edge counts it as an approval event.

## Timing
- All outputs are registered or decoded from registered state; no combinational input-to-output path.
- Event latency: input rising level sampled at CLK edge k.
  - Counters and flags show the update after edge k.
  - `CaixaCheia`/`Bloqueio` assert after the same edge that writes `ItensCaixa=CAPACIDADE`.
- Swap handshake:
  - `TrocaCaixa` rising: seen at edge m, state `TROCA` after m.
  - `TrocaCaixa` falling: seen at edge n > m; after n, `ItensCaixa=0`, `Caixas+1`, `Bloqueio=0`.
  - Minimum swap cost: 2 cycles.
- `TrocaCaixa` is ignored in `ENCHENDO`.
- Back-to-back events: `Conta` must return low for at least one sampled cycle between bottles. Pulses narrower than one clock period may be missed.

## Test plan
- Reset, then 6 single-cycle `Conta` pulses with gaps -> `ItensCaixa` 1..6, `CaixaCheia=1` and `Bloqueio=1` after the 6th; `Caixas=0`.
- Full box; `TrocaCaixa` high 3 cycles then low -> `CaixaCheia` drops after the rising edge; `ItensCaixa=0`, `Caixas=1`, `Bloqueio=0` one edge after the fall.
- `Conta` held high 5 cycles -> `ItensCaixa=1` only.
- 3 `Descarte` pulses -> `Descartes=3`, `Alarme=1`; then one `Conta` pulse -> `Alarme=0` next cycle, `ItensCaixa=1`.
- `Conta` pulse during `CHEIA` -> `Erro=1`, `ItensCaixa` stays 6. `Conta` and `Descarte` rising together in `ENCHENDO` -> `Descartes+1`, `ItensCaixa` unchanged, `Erro=1`.
- 300 discard pulses -> `Descartes=255`. 256 full boxes -> `Caixas` wraps to 0. `Reset` low mid-swap -> all outputs 0 immediately, state `ENCHENDO`.

Source files
------------

// File: rtl/contador_embalagem.sv
// Packaging counter: boxes approved bottles, counts boxes and discards, stops the line
// while a full box is swapped, and raises an alarm on a run of consecutive rejects.
module contador_embalagem #(
  parameter int CAPACIDADE      = 6,
  parameter int LIMITE_DESCARTE = 3
) (
  input  logic       CLK,
  input  logic       Reset,
  input  logic       Conta,
  input  logic       Descarte,
  input  logic       TrocaCaixa,
  output logic [3:0] ItensCaixa,
  output logic [7:0] Caixas,
  output logic [7:0] Descartes,
  output logic       CaixaCheia,
  output logic       Bloqueio,
  output logic       Alarme,
  output logic       Erro
);

  typedef enum logic [1:0] {
    ENCHENDO = 2'd0,
    CHEIA    = 2'd1,
    TROCA    = 2'd2
  } estado_t;

  localparam logic [3:0] CAP = 4'(CAPACIDADE);
  localparam logic [3:0] LIM = 4'(LIMITE_DESCARTE);

  estado_t    estado_q, estado_d;
  logic       conta_ant_q, conta_ant_d;
  logic       descarte_ant_q, descarte_ant_d;
  logic [3:0] itens_q, itens_d;
  logic [7:0] caixas_q, caixas_d;
  logic [7:0] descartes_q, descartes_d;
  logic [3:0] sequencia_q, sequencia_d;
  logic       erro_q, erro_d;

  logic ev_conta, ev_descarte, aprovacao;

  // A simultaneous approval and discard is treated as a discard only.
  assign ev_conta    = Conta & ~conta_ant_q;
  assign ev_descarte = Descarte & ~descarte_ant_q;
  assign aprovacao   = ev_conta & ~ev_descarte;

  always_comb begin
    estado_d       = estado_q;
    conta_ant_d    = Conta;
    descarte_ant_d = Descarte;
    itens_d        = itens_q;
    caixas_d       = caixas_q;
    descartes_d    = descartes_q;
    sequencia_d    = sequencia_q;
    erro_d         = erro_q;

    case (estado_q)
      ENCHENDO: begin
        if (aprovacao) begin
          itens_d = itens_q + 4'd1;
          if (itens_q + 4'd1 == CAP) estado_d = CHEIA;
        end
      end
      CHEIA: begin
        if (aprovacao) erro_d = 1'b1;
        if (TrocaCaixa) estado_d = TROCA;
      end
      TROCA: begin
        if (aprovacao) erro_d = 1'b1;
        if (!TrocaCaixa) begin
          itens_d  = 4'd0;
          caixas_d = caixas_q + 8'd1;
          estado_d = ENCHENDO;
        end
      end
      default: estado_d = ENCHENDO;
    endcase

    if (ev_conta && ev_descarte) erro_d = 1'b1;

    if (ev_descarte) begin
      if (descartes_q != 8'hFF) descartes_d = descartes_q + 8'd1;
      if (sequencia_q != 4'hF) sequencia_d = sequencia_q + 4'd1;
    end else if (aprovacao) begin
      sequencia_d = 4'd0;
    end
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      estado_q       <= ENCHENDO;
      conta_ant_q    <= 1'b0;
      descarte_ant_q <= 1'b0;
      itens_q        <= 4'd0;
      caixas_q       <= 8'd0;
      descartes_q    <= 8'd0;
      sequencia_q    <= 4'd0;
      erro_q         <= 1'b0;
    end else begin
      estado_q       <= estado_d;
      conta_ant_q    <= conta_ant_d;
      descarte_ant_q <= descarte_ant_d;
      itens_q        <= itens_d;
      caixas_q       <= caixas_d;
      descartes_q    <= descartes_d;
      sequencia_q    <= sequencia_d;
      erro_q         <= erro_d;
    end
  end

  assign ItensCaixa = itens_q;
  assign Caixas     = caixas_q;
  assign Descartes  = descartes_q;
  assign CaixaCheia = (estado_q == CHEIA);
  assign Bloqueio   = (estado_q != ENCHENDO);
  assign Alarme     = (sequencia_q >= LIM);
  assign Erro       = erro_q;

endmodule

// File: tb/tb_contador_embalagem.sv
// Scoreboard bench for contador_embalagem: directed stimulus queues hand-computed
// expectations; an independent monitor compares them against the outputs.
module tb_contador_embalagem;

  logic       CLK = 1'b0;
  logic       Reset, Conta, Descarte, TrocaCaixa;
  logic [3:0] ItensCaixa;
  logic [7:0] Caixas, Descartes;
  logic       CaixaCheia, Bloqueio, Alarme, Erro;

  contador_embalagem #(.CAPACIDADE(6), .LIMITE_DESCARTE(3)) dut (
    .CLK(CLK), .Reset(Reset), .Conta(Conta), .Descarte(Descarte),
    .TrocaCaixa(TrocaCaixa), .ItensCaixa(ItensCaixa), .Caixas(Caixas),
    .Descartes(Descartes), .CaixaCheia(CaixaCheia), .Bloqueio(Bloqueio),
    .Alarme(Alarme), .Erro(Erro)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string      name;
    int         cyc;
    logic [3:0] itens;
    logic [7:0] caixas;
    logic [7:0] descartes;
    logic       cheia, bloq, alarme, erro;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   cyc_cnt = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  event chk_ev;

  always @(posedge CLK) cyc_cnt <= cyc_cnt + 1;

  // Monitor: compares every queued expectation whose sample point has arrived.
  initial begin
    exp_t x;
    forever begin
      @(negedge CLK or chk_ev);
      while (q.size() > 0 && q[0].cyc <= cyc_cnt) begin
        x = q.pop_front();
        n_chk++;
        if (ItensCaixa !== x.itens || Caixas !== x.caixas || Descartes !== x.descartes ||
            CaixaCheia !== x.cheia || Bloqueio !== x.bloq || Alarme !== x.alarme ||
            Erro !== x.erro) begin
          n_fail++;
          $display("FAIL %s: got itens=%0d caixas=%0d descartes=%0d cheia=%b bloq=%b alarme=%b erro=%b, required itens=%0d caixas=%0d descartes=%0d cheia=%b bloq=%b alarme=%b erro=%b",
                   x.name, ItensCaixa, Caixas, Descartes, CaixaCheia, Bloqueio, Alarme, Erro,
                   x.itens, x.caixas, x.descartes, x.cheia, x.bloq, x.alarme, x.erro);
        end
      end
    end
  end

  function automatic void clear_exp();
    e.itens = 4'd0; e.caixas = 8'd0; e.descartes = 8'd0;
    e.cheia = 1'b0; e.bloq = 1'b0; e.alarme = 1'b0; e.erro = 1'b0;
  endfunction

  // Expectation for the outputs after the upcoming rising edge.
  task automatic push(input string nm);
    e.name = nm;
    e.cyc  = cyc_cnt + 1;
    q.push_back(e);
  endtask

  task automatic cyc_in(input logic c, input logic d, input logic t);
    @(negedge CLK);
    Conta = c; Descarte = d; TrocaCaixa = t;
  endtask

  // Asserts reset between clock edges and checks outputs before any edge arrives.
  task automatic do_reset(input string nm, input logic conta_hold);
    @(negedge CLK);
    #2;
    Reset = 1'b0;
    clear_exp();
    #1;
    e.name = nm;
    e.cyc  = cyc_cnt;
    q.push_back(e);
    -> chk_ev;
    @(negedge CLK);
    @(negedge CLK);
    Reset = 1'b1;
    Conta = conta_hold; Descarte = 1'b0; TrocaCaixa = 1'b0;
  endtask

  task automatic conta_pulse(input string nm);
    cyc_in(1'b1, 1'b0, 1'b0);
    push(nm);
    cyc_in(1'b0, 1'b0, 1'b0);
  endtask

  task automatic fill_box();
    for (int i = 1; i <= 6; i++) begin
      cyc_in(1'b1, 1'b0, 1'b0);
      e.itens = 4'(i);
      e.alarme = 1'b0;
      if (i == 6) begin e.cheia = 1'b1; e.bloq = 1'b1; end
      cyc_in(1'b0, 1'b0, 1'b0);
    end
  endtask

  initial begin
    Reset = 1'b0; Conta = 1'b0; Descarte = 1'b0; TrocaCaixa = 1'b0;
    clear_exp();
    #1;
    e.name = "reset_state"; e.cyc = cyc_cnt; q.push_back(e);
    -> chk_ev;
    @(negedge CLK); @(negedge CLK);
    Reset = 1'b1;

    // Fill a box with six separated pulses.
    for (int i = 1; i <= 6; i++) begin
      e.itens = 4'(i);
      if (i == 6) begin e.cheia = 1'b1; e.bloq = 1'b1; end
      conta_pulse($sformatf("fill_%0d", i));
    end

    // Swap: TrocaCaixa high 3 cycles, then low.
    e.cheia = 1'b0; e.bloq = 1'b1;
    for (int i = 0; i < 3; i++) begin cyc_in(1'b0, 1'b0, 1'b1); push("swap_hold"); end
    cyc_in(1'b0, 1'b0, 1'b0);
    e.itens = 4'd0; e.caixas = 8'd1; e.bloq = 1'b0;
    push("swap_done");

    // Conta held high five cycles counts once.
    e.itens = 4'd1;
    for (int i = 0; i < 5; i++) begin cyc_in(1'b1, 1'b0, 1'b0); push("conta_held"); end
    cyc_in(1'b0, 1'b0, 1'b0);

    // Three discards raise the alarm; an approval clears it.
    for (int i = 1; i <= 3; i++) begin
      cyc_in(1'b0, 1'b1, 1'b0);
      e.descartes = 8'(i);
      e.alarme = (i == 3);
      push($sformatf("discard_%0d", i));
      cyc_in(1'b0, 1'b0, 1'b0);
    end
    e.itens = 4'd2; e.alarme = 1'b0;
    conta_pulse("alarm_clear");

    // Simultaneous events: discard only, error set, run not cleared.
    for (int i = 4; i <= 5; i++) begin
      cyc_in(1'b0, 1'b1, 1'b0);
      e.descartes = 8'(i);
      cyc_in(1'b0, 1'b0, 1'b0);
    end
    cyc_in(1'b1, 1'b1, 1'b0);
    e.descartes = 8'd6; e.alarme = 1'b1; e.erro = 1'b1;
    push("simultaneous");
    cyc_in(1'b0, 1'b0, 1'b0);
    e.itens = 4'd3; e.alarme = 1'b0;
    conta_pulse("after_simult");

    // TrocaCaixa ignored while filling; approval in CHEIA flags error.
    do_reset("reset_clears_erro", 1'b0);
    cyc_in(1'b0, 1'b0, 1'b1);
    push("troca_ignored");
    cyc_in(1'b0, 1'b0, 1'b0);
    fill_box();
    e.erro = 1'b1;
    conta_pulse("conta_in_cheia");
    cyc_in(1'b0, 1'b0, 1'b1);
    e.cheia = 1'b0;
    push("cheia_to_troca");
    cyc_in(1'b0, 1'b0, 1'b0);
    e.itens = 4'd0; e.caixas = 8'd1; e.bloq = 1'b0;
    push("troca_done_erro_sticky");

    // Discard saturation.
    do_reset("reset_before_sat", 1'b0);
    for (int i = 1; i <= 300; i++) begin
      cyc_in(1'b0, 1'b1, 1'b0);
      e.descartes = (i > 255) ? 8'd255 : 8'(i);
      e.alarme = (i >= 3);
      if (i <= 3 || i == 254 || i == 255 || i == 256 || i == 300) push($sformatf("sat_%0d", i));
      cyc_in(1'b0, 1'b0, 1'b0);
    end

    // Box counter wrap.
    for (int k = 1; k <= 256; k++) begin
      fill_box();
      cyc_in(1'b0, 1'b0, 1'b1);
      cyc_in(1'b0, 1'b0, 1'b0);
      e.itens = 4'd0; e.cheia = 1'b0; e.bloq = 1'b0; e.caixas = 8'(k % 256);
      if (k == 1 || k == 255 || k == 256) push($sformatf("box_%0d", k));
    end

    // Reset mid-swap, with Conta held through the release.
    fill_box();
    push("full_before_reset");
    cyc_in(1'b0, 1'b0, 1'b1);
    e.cheia = 1'b0;
    push("troca_before_reset");
    do_reset("reset_mid_swap", 1'b1);
    e.itens = 4'd1;
    push("conta_through_reset");
    cyc_in(1'b0, 1'b0, 1'b0);

    repeat (3) @(negedge CLK);
    if (q.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain: got %0d pending expectations, required 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
